// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: parity encodings, FSM state codes
// and the baud divisor calculation.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    // Clocks per oversample tick, truncated and never below one.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        int unsigned d;
        d = clk_freq / (baud_rate * oversample);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter, one-clock tick on
// wrap; clr restarts the phase so a bit period begins exactly at clr.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART with programmable framing, oversampled
// mid-bit RX sampling and per-frame error reporting.
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 40000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       ser_tx,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned   DIV     = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned   OW      = $clog2(OVERSAMPLE);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_HALF = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [7:0]    DMASK   = 8'((1 << DATA_BITS) - 1);
    localparam logic          ODD_INV = (PARITY == PAR_ODD);

    // ---------------- transmitter ----------------
    logic [2:0]    tx_state_q, tx_state_d;
    logic [OW-1:0] tx_os_q, tx_os_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_par_q, tx_par_d;
    logic          tx_ser_q, tx_ser_d;
    logic          tx_busy_q, tx_busy_d;
    logic          tx_done_q, tx_done_d;
    logic          tx_tick, tx_clr, tx_bit_end;

    uart_baud_tick #(.DIV(DIV)) u_tx_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tx_clr),
        .tick  (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_ser_d   = tx_ser_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        tx_clr     = 1'b0;
        tx_bit_end = 1'b0;

        if ((tx_state_q != TX_IDLE) && tx_tick) begin
            if (tx_os_q == OS_LAST) begin
                tx_os_d    = '0;
                tx_bit_end = 1'b1;
            end else begin
                tx_os_d = tx_os_q + 1'b1;
            end
        end

        case (tx_state_q)
            TX_IDLE: begin
                // A start in the tx_done cycle is ignored until the next cycle.
                if (tx_start && !tx_done_q) begin
                    tx_clr     = 1'b1;
                    tx_os_d    = '0;
                    tx_bit_d   = '0;
                    tx_shift_d = tx_data & DMASK;
                    tx_par_d   = (^(tx_data & DMASK)) ^ ODD_INV;
                    tx_ser_d   = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_ser_d   = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                        tx_bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            tx_state_d = TX_PARITY;
                            tx_ser_d   = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_ser_d   = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_ser_d   = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_ser_d   = 1'b1;
                    tx_bit_d   = '0;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 3'(STOP_BITS - 1)) begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                        tx_busy_d  = 1'b0;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_ser_d   = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_ser_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_ser_q   <= tx_ser_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign ser_tx  = tx_ser_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

    // ---------------- receiver ----------------
    logic                 rx_meta_q, rx_s_q;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [OW-1:0]        rx_os_q, rx_os_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_wait_q, rx_wait_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_par_out_q, rx_par_out_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_tick, rx_clr, rx_sample;

    uart_baud_tick #(.DIV(DIV)) u_rx_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rx_clr),
        .tick  (rx_tick)
    );

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_os_d      = rx_os_q;
        rx_bit_d     = rx_bit_q;
        rx_sh_d      = rx_sh_q;
        rx_perr_d    = rx_perr_q;
        rx_wait_d    = rx_wait_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_par_out_d = rx_par_out_q;
        rx_ferr_d    = rx_ferr_q;
        rx_ovr_d     = 1'b0;
        rx_clr       = 1'b0;
        rx_sample    = 1'b0;

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // START samples at half a bit; every later state at full bit periods.
        if ((rx_state_q != RX_IDLE) && rx_tick) begin
            if (rx_os_q == ((rx_state_q == RX_START) ? OS_HALF : OS_LAST)) begin
                rx_os_d   = '0;
                rx_sample = 1'b1;
            end else begin
                rx_os_d = rx_os_q + 1'b1;
            end
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    rx_clr     = 1'b1;
                    rx_os_d    = '0;
                    rx_perr_d  = 1'b0;
                    rx_wait_d  = 1'b0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    rx_bit_d   = '0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_sh_d = {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == 3'(DATA_BITS - 1)) begin
                        rx_bit_d   = '0;
                        rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_perr_d  = rx_s_q ^ ((^rx_sh_q) ^ ODD_INV);
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // After the stop sample, hold here until the line idles high so
                // a break is not mistaken for a new start bit.
                if (rx_wait_q) begin
                    if (rx_s_q) rx_state_d = RX_IDLE;
                end else if (rx_sample) begin
                    rx_wait_d = 1'b1;
                    if (!rx_valid_q || rx_ready) begin
                        rx_data_d    = 8'(rx_sh_q);
                        rx_par_out_d = rx_perr_q;
                        rx_ferr_d    = !rx_s_q;
                        rx_valid_d   = 1'b1;
                    end else begin
                        rx_ovr_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_os_q      <= '0;
            rx_bit_q     <= '0;
            rx_sh_q      <= '0;
            rx_perr_q    <= 1'b0;
            rx_wait_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_par_out_q <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_ovr_q     <= 1'b0;
        end else begin
            rx_meta_q    <= ser_rx;
            rx_s_q       <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            rx_os_q      <= rx_os_d;
            rx_bit_q     <= rx_bit_d;
            rx_sh_q      <= rx_sh_d;
            rx_perr_q    <= rx_perr_d;
            rx_wait_q    <= rx_wait_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_par_out_q <= rx_par_out_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_ovr_q     <= rx_ovr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_par_out_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: three instances (8N1, 7E2 loopback, 8O1)
// at 16 clocks per bit.
module tb_uart_core;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: 8N1, RX driven by the bench
    logic       tx_start_a, tx_busy_a, tx_done_a, ser_tx_a, rx_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       rx_valid_a, rx_ready_a, rx_perr_a, rx_ferr_a, rx_ovr_a;
    // Instance B: 7E2, loopback
    logic       tx_start_b, tx_busy_b, tx_done_b, ser_tx_b;
    logic [7:0] tx_data_b, rx_data_b;
    logic       rx_valid_b, rx_ready_b, rx_perr_b, rx_ferr_b, rx_ovr_b;
    // Instance C: 8O1, RX driven by the bench
    logic       tx_start_c, tx_busy_c, tx_done_c, ser_tx_c, rx_c;
    logic [7:0] tx_data_c, rx_data_c;
    logic       rx_valid_c, rx_ready_c, rx_perr_c, rx_ferr_c, rx_ovr_c;

    int n_assert = 0;
    int n_fail   = 0;
    int ovr_seen = 0;

    uart_core #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start_a), .tx_data(tx_data_a),
        .tx_busy(tx_busy_a), .tx_done(tx_done_a), .ser_tx(ser_tx_a), .ser_rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .rx_overrun(rx_ovr_a)
    );

    uart_core #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start_b), .tx_data(tx_data_b),
        .tx_busy(tx_busy_b), .tx_done(tx_done_b), .ser_tx(ser_tx_b), .ser_rx(ser_tx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b), .rx_overrun(rx_ovr_b)
    );

    uart_core #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start_c), .tx_data(tx_data_c),
        .tx_busy(tx_busy_c), .tx_done(tx_done_c), .ser_tx(ser_tx_c), .ser_rx(rx_c),
        .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c),
        .rx_parity_err(rx_perr_c), .rx_frame_err(rx_ferr_c), .rx_overrun(rx_ovr_c)
    );

    always @(negedge clk) if (rx_ovr_a) ovr_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame bits are sent LSB first, 16 clocks each; line returns high after.
    task automatic drive_frame(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx_a = bits[i];
            else          rx_c = bits[i];
            repeat (16) @(negedge clk);
        end
        if (sel == 0) rx_a = 1'b1;
        else          rx_c = 1'b1;
    endtask

    function automatic logic valid_of(input int sel);
        if (sel == 0) return rx_valid_a;
        if (sel == 1) return rx_valid_c;
        return rx_valid_b;
    endfunction

    task automatic wait_valid(input int sel, input int budget);
        for (int i = 0; i < budget && !valid_of(sel); i++) @(negedge clk);
    endtask

    task automatic wait_not_busy_a(input int budget);
        for (int i = 0; i < budget && tx_busy_a; i++) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  exp_a;
        logic [10:0] exp_b;
        int          ovr_before;

        rst_n = 1'b0;
        tx_start_a = 1'b0; tx_data_a = '0; rx_a = 1'b1; rx_ready_a = 1'b0;
        tx_start_b = 1'b0; tx_data_b = '0; rx_ready_b = 1'b0;
        tx_start_c = 1'b0; tx_data_c = '0; rx_c = 1'b1; rx_ready_c = 1'b0;
        repeat (5) @(negedge clk);

        check("rst ser_tx", 32'(ser_tx_a), 32'd1);
        check("rst tx_busy", 32'(tx_busy_a), 32'd0);
        check("rst tx_done", 32'(tx_done_a), 32'd0);
        check("rst rx_data", 32'(rx_data_a), 32'h00);
        check("rst rx_valid", 32'(rx_valid_a), 32'd0);
        check("rst flags", 32'({rx_perr_a, rx_ferr_a, rx_ovr_a}), 32'd0);
        check("rst ser_tx_b", 32'(ser_tx_b), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 25 == 24) begin
                check("idle ser_tx", 32'(ser_tx_a), 32'd1);
                check("idle tx_busy", 32'(tx_busy_a), 32'd0);
                check("idle rx_valid", 32'(rx_valid_a), 32'd0);
            end
        end

        // TX 8N1 0xA5: start, 1010_0101 LSB first, stop
        exp_a = {1'b1, 8'hA5, 1'b0};
        tx_data_a = 8'hA5; tx_start_a = 1'b1;
        @(negedge clk);
        tx_start_a = 1'b0;
        for (int t = 0; t <= 160; t++) begin
            if (t == 0) check("tx busy clk0", 32'(tx_busy_a), 32'd1);
            if (t % 16 == 8) check($sformatf("tx8n1 bit%0d", t / 16), 32'(ser_tx_a), 32'(exp_a[t / 16]));
            if (t == 50) begin tx_start_a = 1'b1; tx_data_a = 8'hFF; end
            if (t == 51) tx_start_a = 1'b0;
            if (t == 159) begin
                check("tx busy clk159", 32'(tx_busy_a), 32'd1);
                check("tx done clk159", 32'(tx_done_a), 32'd0);
            end
            if (t == 160) begin
                check("tx done clk160", 32'(tx_done_a), 32'd1);
                check("tx busy clk160", 32'(tx_busy_a), 32'd0);
            end
            if (t < 160) @(negedge clk);
        end
        // Start during the tx_done cycle is ignored, accepted one cycle later.
        tx_start_a = 1'b1;
        @(negedge clk);
        check("start in done cycle ignored", 32'(tx_busy_a), 32'd0);
        check("tx done one cycle", 32'(tx_done_a), 32'd0);
        @(negedge clk);
        tx_start_a = 1'b0;
        check("start after done accepted", 32'(tx_busy_a), 32'd1);
        wait_not_busy_a(200);
        check("second frame finishes", 32'(tx_busy_a), 32'd0);

        // TX 7E2 0x53 (bit 7 set must be ignored) with loopback into RX
        exp_b = {2'b11, 1'b0, 7'h53, 1'b0};
        tx_data_b = 8'hD3; tx_start_b = 1'b1;
        @(negedge clk);
        tx_start_b = 1'b0;
        for (int t = 0; t <= 176; t++) begin
            if (t % 16 == 8 && t < 176) check($sformatf("tx7e2 bit%0d", t / 16), 32'(ser_tx_b), 32'(exp_b[t / 16]));
            if (t == 175) check("7e2 busy clk175", 32'(tx_busy_b), 32'd1);
            if (t == 176) begin
                check("7e2 done clk176", 32'(tx_done_b), 32'd1);
                check("7e2 busy clk176", 32'(tx_busy_b), 32'd0);
            end
            if (t < 176) @(negedge clk);
        end
        wait_valid(2, 100);
        check("loop rx_valid", 32'(rx_valid_b), 32'd1);
        check("loop rx_data", 32'(rx_data_b), 32'h53);
        check("loop parity_err", 32'(rx_perr_b), 32'd0);
        check("loop frame_err", 32'(rx_ferr_b), 32'd0);

        // RX glitch: 4-clock low pulse produces no frame
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch no frame", 32'(rx_valid_a), 32'd0);

        // Frame 0x3C with stop bit low
        drive_frame(0, 16'({1'b0, 8'h3C, 1'b0}), 10);
        wait_valid(0, 60);
        check("ferr rx_valid", 32'(rx_valid_a), 32'd1);
        check("ferr rx_data", 32'(rx_data_a), 32'h3C);
        check("ferr frame_err", 32'(rx_ferr_a), 32'd1);
        check("ferr parity_err", 32'(rx_perr_a), 32'd0);
        repeat (20) @(negedge clk);
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
        check("consume drops valid", 32'(rx_valid_a), 32'd0);

        // Overrun: two frames with rx_ready low
        ovr_before = ovr_seen;
        drive_frame(0, 16'({1'b1, 8'h11, 1'b0}), 10);
        drive_frame(0, 16'({1'b1, 8'h22, 1'b0}), 10);
        repeat (4) @(negedge clk);
        check("overrun pulses", 32'(ovr_seen - ovr_before), 32'd1);
        check("overrun rx_valid", 32'(rx_valid_a), 32'd1);
        check("overrun keeps data", 32'(rx_data_a), 32'h11);
        check("overrun keeps frame_err", 32'(rx_ferr_a), 32'd0);
        check("overrun pulse ended", 32'(rx_ovr_a), 32'd0);
        rx_ready_a = 1'b1;
        check("valid before consume edge", 32'(rx_valid_a), 32'd1);
        @(negedge clk);
        rx_ready_a = 1'b0;
        check("overrun consume drops valid", 32'(rx_valid_a), 32'd0);

        // Odd parity: 0x01 needs parity 0, send 1 -> error
        drive_frame(1, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11);
        wait_valid(1, 60);
        check("odd rx_valid", 32'(rx_valid_c), 32'd1);
        check("odd rx_data", 32'(rx_data_c), 32'h01);
        check("odd parity_err", 32'(rx_perr_c), 32'd1);
        check("odd frame_err", 32'(rx_ferr_c), 32'd0);
        rx_ready_c = 1'b1;
        @(negedge clk);
        rx_ready_c = 1'b0;
        // 0x03 needs parity 1 -> clean
        drive_frame(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
        wait_valid(1, 60);
        check("odd ok rx_data", 32'(rx_data_c), 32'h03);
        check("odd ok parity_err", 32'(rx_perr_c), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Synthesisable, parametrised full-duplex UART. Successor to the fixed 9600-baud 8N1 bench UART model.
- Derives bit timing from the system clock through a programmable divisor. Adds configurable data bits, parity, stop bits and oversampled mid-bit RX sampling.
- Reports errors per frame. Sits between a memory-mapped or stream host and the chip's serial pins; also reused as a bench-side UART peer.

Parameters:
- CLK_FREQ, 40000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in baud.
- OVERSAMPLE, 16, ticks per bit; even, at least 4.
- DATA_BITS, 8, payload bits per frame, 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- DIV, CLK_FREQ/(BAUD_RATE*OVERSAMPLE), derived localparam; clocks per tick, truncated, minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_start  in  1  request to send tx_data; accepted only while tx_busy=0.
- tx_data  in  8  payload; bits [DATA_BITS-1:0] used, upper bits ignored.
- tx_busy  out  1  transmitter occupied.
- tx_done  out  1  one-cycle pulse when the last stop bit ends.
- ser_tx  out  1  serial output, idle high.
- ser_rx  in  1  serial input, asynchronous.
- rx_data  out  8  received payload, zero-extended.
- rx_valid  out  1  rx_data holds an unread frame.
- rx_ready  in  1  host consumes rx_data when rx_valid=1.
- rx_parity_err  out  1  qualifies rx_data; valid while rx_valid=1.
- rx_frame_err  out  1  stop bit sampled low; valid while rx_valid=1.
- rx_overrun  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset values: ser_tx=1, tx_busy=0, tx_done=0, rx_data=0, rx_valid=0, both error flags=0, rx_overrun=0. All counters 0; both FSMs in IDLE.
- Reset asserted mid-frame aborts immediately; ser_tx returns to 1 asynchronously.
- Tick generator: free-running counter 0..DIV-1. The tick pulse lasts 1 clk and fires when the counter wraps. Tick count per bit is OVERSAMPLE.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with tx_start=1: latch tx_data and set tx_busy=1 on that edge. Next cycle ser_tx=0 and the FSM enters START. The bit tick counter restarts at 0 on accept, so every bit lasts exactly OVERSAMPLE*DIV clocks.
  - DATA sends LSB first for DATA_BITS bits.
  - PARITY (skipped if PARITY=0) sends the XOR of the payload, inverted for odd parity.
  - STOP drives 1 for STOP_BITS bit times.
  - At the end of STOP: tx_done=1 for one cycle, tx_busy=0 in the same cycle, return to IDLE.
  - tx_start while busy is ignored, with no queuing.
  - tx_start in the same cycle as tx_done is ignored; it is accepted from the next cycle.
- RX input: ser_rx passes through a 2-FF synchroniser; all RX logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling level (sync=0) resets the tick phase and enters START.
  - START: after OVERSAMPLE/2 ticks, resample. If 1, treat as a glitch and return to IDLE with no flags.
  - DATA: sample every OVERSAMPLE ticks (bit centre), shifting right into a DATA_BITS register.
  - PARITY: sample and compare.
  - STOP: sample the first stop bit only; a 0 sets the frame error. The FSM then waits for the line to be high before returning to IDLE (break handling).
- Frame completion at the stop sample:
  - If rx_valid=0 or rx_ready=1 in that cycle: load rx_data and the flags, set rx_valid=1.
  - Otherwise: rx_overrun pulses, and the old data and flags are kept.
- Handshake: rx_valid falls the cycle after rx_valid&&rx_ready. If consumption and a new completion coincide, the new frame loads and rx_valid stays 1.
- TX and RX are fully independent; loopback of ser_tx to ser_rx must work.

Decomposition:
- Shared package uart_pkg: parity encoding constants (PAR_NONE/ODD/EVEN), FSM state encodings for TX and RX (3-bit), and the function computing DIV with its minimum-1 clamp.
- Sub-module uart_baud_tick (parameter DIV; ports clk, rst_n, clr, tick). Instantiated twice, so the TX and RX phases restart independently.

Test Plan (CLK_FREQ=16000000, BAUD_RATE=1000000, OVERSAMPLE=16 ⇒ DIV=1, 16 clk/bit):
- Reset/idle: rst_n low 5 cycles, then release -> ser_tx=1, tx_busy=0, rx_valid=0 for 100 cycles.
- TX 8N1: tx_data=0xA5, tx_start pulse -> ser_tx pattern 0,1,0,1,0,0,1,0,1,1 at 16 clk per bit; tx_done at clk 160 after accept; tx_busy high for clk 0..159.
- TX 7E2 plus loopback: DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x53 -> parity bit 0, frame 176 clk; RX returns rx_data=0x53 with no errors.
- RX glitch and framing: ser_rx low for 4 clk -> no frame. Then frame 0x3C with stop=0 -> rx_valid=1, rx_data=0x3C, rx_frame_err=1.
- Odd parity error: PARITY=1, inject 0x01 with parity bit 1 -> rx_parity_err=1.
- Overrun: two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_overrun pulse at the second stop sample, rx_data stays 0x11. Asserting rx_ready then drops rx_valid the next cycle.
